// File: rtl/decode_stage_if.sv
// Decode-stage bus: fetch handoff, register-file read, producer status for
// forwarding/stall, and the handoff to execute.
interface decode_stage_if;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        ds_allowin;

    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;

    logic        es_valid;
    logic        es_wen;
    logic        es_is_load;
    logic [4:0]  es_waddr;
    logic [31:0] es_result;
    logic        ms_valid;
    logic        ms_wen;
    logic [4:0]  ms_waddr;
    logic [31:0] ms_result;
    logic        ws_valid;
    logic        ws_wen;
    logic [4:0]  ws_waddr;
    logic [31:0] ws_wdata;

    logic        flush;
    logic        es_allowin;
    logic        ds_to_es_valid;
    logic [31:0] ds_pc;
    logic [31:0] ds_inst;
    logic [31:0] ds_src1;
    logic [31:0] ds_src2;
    logic [31:0] ds_imm;
    logic [4:0]  ds_dest;

    // Surrounding pipeline view.
    modport master (
        output fs_valid, fs_pc, fs_inst, rf_rdata1, rf_rdata2,
        output es_valid, es_wen, es_is_load, es_waddr, es_result,
        output ms_valid, ms_wen, ms_waddr, ms_result,
        output ws_valid, ws_wen, ws_waddr, ws_wdata, flush, es_allowin,
        input  ds_allowin, rf_raddr1, rf_raddr2, ds_to_es_valid,
        input  ds_pc, ds_inst, ds_src1, ds_src2, ds_imm, ds_dest
    );

    // Decode-stage view.
    modport slave (
        input  fs_valid, fs_pc, fs_inst, rf_rdata1, rf_rdata2,
        input  es_valid, es_wen, es_is_load, es_waddr, es_result,
        input  ms_valid, ms_wen, ms_waddr, ms_result,
        input  ws_valid, ws_wen, ws_waddr, ws_wdata, flush, es_allowin,
        output ds_allowin, rf_raddr1, rf_raddr2, ds_to_es_valid,
        output ds_pc, ds_inst, ds_src1, ds_src2, ds_imm, ds_dest
    );
endinterface

// File: rtl/decode_stage.sv
// Single-entry decode stage: holds one instruction, decodes fields, forwards
// operands from ES/MS/WS and stalls on a load-use hazard.
module decode_stage (
    input  logic          clk,
    input  logic          rstn,
    decode_stage_if.slave bus
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    logic        ds_valid_q, ds_valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic        rs_used, rt_used;
    logic        load_use, ds_ready_go, ds_allowin;
    logic        es_fwd_ok, ms_fwd_ok, ws_fwd_ok;

    assign opcode = inst_q[31:26];
    assign rs     = inst_q[25:21];
    assign rt     = inst_q[20:16];
    assign rd     = inst_q[15:11];

    assign rs_used = (opcode != OP_J) && (opcode != OP_JAL);
    assign rt_used = (opcode == OP_SPECIAL) || (opcode == OP_SW) ||
                     (opcode == OP_BEQ)     || (opcode == OP_BNE);

    // A load in ES has no data yet, so it is excluded from forwarding and stalls instead.
    assign es_fwd_ok = bus.es_valid && bus.es_wen && !bus.es_is_load;
    assign ms_fwd_ok = bus.ms_valid && bus.ms_wen;
    assign ws_fwd_ok = bus.ws_valid && bus.ws_wen;

    assign load_use = ds_valid_q && bus.es_valid && bus.es_is_load && bus.es_wen &&
                      (bus.es_waddr != 5'd0) &&
                      ((rs_used && (bus.es_waddr == rs)) || (rt_used && (bus.es_waddr == rt)));

    assign ds_ready_go        = !load_use;
    assign ds_allowin         = !ds_valid_q || (ds_ready_go && bus.es_allowin);
    assign bus.ds_allowin     = ds_allowin;
    assign bus.ds_to_es_valid = ds_valid_q && ds_ready_go && !bus.flush;

    function automatic logic [31:0] fwd_value(
        input logic [4:0]  addr,
        input logic [31:0] rf_data,
        input logic        es_ok, input logic [4:0] es_a, input logic [31:0] es_d,
        input logic        ms_ok, input logic [4:0] ms_a, input logic [31:0] ms_d,
        input logic        ws_ok, input logic [4:0] ws_a, input logic [31:0] ws_d
    );
        if (addr == 5'd0)                   return 32'd0;
        else if (es_ok && (es_a == addr))   return es_d;
        else if (ms_ok && (ms_a == addr))   return ms_d;
        else if (ws_ok && (ws_a == addr))   return ws_d;
        else                                return rf_data;
    endfunction

    assign bus.rf_raddr1 = rs;
    assign bus.rf_raddr2 = rt;
    assign bus.ds_pc     = pc_q;
    assign bus.ds_inst   = inst_q;
    assign bus.ds_imm    = {{16{inst_q[15]}}, inst_q[15:0]};

    assign bus.ds_src1 = fwd_value(rs, bus.rf_rdata1,
                                   es_fwd_ok, bus.es_waddr, bus.es_result,
                                   ms_fwd_ok, bus.ms_waddr, bus.ms_result,
                                   ws_fwd_ok, bus.ws_waddr, bus.ws_wdata);
    assign bus.ds_src2 = fwd_value(rt, bus.rf_rdata2,
                                   es_fwd_ok, bus.es_waddr, bus.es_result,
                                   ms_fwd_ok, bus.ms_waddr, bus.ms_result,
                                   ws_fwd_ok, bus.ws_waddr, bus.ws_wdata);

    always_comb begin
        if (opcode == OP_SPECIAL)                          bus.ds_dest = rd;
        else if ((opcode == OP_LW) || (opcode[5:3] == 3'b001)) bus.ds_dest = rt;
        else                                               bus.ds_dest = 5'd0;
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        ds_valid_d = ds_valid_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        if (bus.flush) begin
            ds_valid_d = 1'b0;
        end else if (ds_allowin) begin
            ds_valid_d = bus.fs_valid;
            if (bus.fs_valid) begin
                pc_d   = bus.fs_pc;
                inst_d = bus.fs_inst;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values together.
        if (!rstn) begin
            ds_valid_q <= 1'b0;
            pc_q       <= 32'd0;
            inst_q     <= 32'd0;
        end else begin
            ds_valid_q <= ds_valid_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
        end
    end

endmodule
